// File: rtl/maxnet_controller.sv
// maxnet_controller: sequencer for a four-input MAXNET winner-take-all datapath.
//
// Each run does the following:
//   1. Loads the X registers.
//   2. Repeats LOAD_PU -> MUL -> SUM -> CHECK until the datapath reports convergence (S=1).
//   3. Pulses done for one cycle.
//
// The first LOAD_PU of a run selects the X registers. Every later LOAD_PU selects the fed-back
// PU outputs.
//
// Optional feature (macro MAXNET_TIMEOUT_EN):
//   Defined   - the run also ends, with timeout=1, once MAX_ITER iterations complete without
//               convergence.
//   Undefined - the run iterates until S=1, timeout stays 0, and iter_cnt saturates at 15.
//
// Parameters:
//   MAX_ITER       iteration limit (1..15), used only with MAXNET_TIMEOUT_EN
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   start          run request, sampled in IDLE only
//   S              convergence flag from the datapath, sampled in CHECK only
//   input_en       load X registers (LOAD_X)
//   load_in        load PU input registers (LOAD_PU)
//   sel_old_or_new 0: X registers, 1: fed-back PU outputs (meaningful in LOAD_PU)
//   mul_en         PU multiply-stage enable (MUL)
//   sum_en         PU sum-stage enable (SUM)
//   busy           high in every state except IDLE
//   done           one-cycle completion pulse (DONE)
//   timeout        completion was caused by the iteration limit
//   iter_cnt       number of completed iterations, held until the next accepted start
module maxnet_controller #(
  parameter int unsigned MAX_ITER = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       S,
  output logic       input_en,
  output logic       load_in,
  output logic       sel_old_or_new,
  output logic       mul_en,
  output logic       sum_en,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic [3:0] iter_cnt
);

  typedef enum logic [2:0] {
    StIdle,
    StLoadX,
    StLoadPu,
    StMul,
    StSum,
    StCheck,
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] iter_q, iter_d;
  logic       timeout_q, timeout_d;
  logic [3:0] iter_inc;

  assign iter_inc = iter_q + 4'd1;

`ifdef MAXNET_TIMEOUT_EN
  localparam logic [3:0] IterLimit = 4'(MAX_ITER);
`else
  logic unused_max_iter;
  assign unused_max_iter = ^MAX_ITER;
`endif

  always_comb begin
    state_d        = state_q;
    iter_d         = iter_q;
    timeout_d      = timeout_q;
    input_en       = 1'b0;
    load_in        = 1'b0;
    sel_old_or_new = 1'b0;
    mul_en         = 1'b0;
    sum_en         = 1'b0;
    done           = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StLoadX;
          iter_d    = 4'd0;
          timeout_d = 1'b0;
        end
      end

      StLoadX: begin
        input_en = 1'b1;
        state_d  = StLoadPu;
      end

      StLoadPu: begin
        load_in = 1'b1;
        // The count is zero only before the first CHECK of a run.
        // So a nonzero count means the PU outputs should be fed back.
        sel_old_or_new = (iter_q != 4'd0);
        state_d        = StMul;
      end

      StMul: begin
        mul_en  = 1'b1;
        state_d = StSum;
      end

      StSum: begin
        sum_en  = 1'b1;
        state_d = StCheck;
      end

      StCheck: begin
`ifdef MAXNET_TIMEOUT_EN
        iter_d = iter_inc;
        if (S) begin
          // Convergence wins over the limit in the same cycle.
          state_d = StDone;
        end else if (iter_inc == IterLimit) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end else begin
          state_d = StLoadPu;
        end
`else
        iter_d  = (iter_q == 4'hf) ? iter_q : iter_inc;
        state_d = S ? StDone : StLoadPu;
`endif
      end

      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  assign busy     = (state_q != StIdle);
  assign iter_cnt = iter_q;
  assign timeout  = timeout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      iter_q    <= 4'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      iter_q    <= iter_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_maxnet_controller.sv
// Testbench for maxnet_controller.
//
// Each planned cycle is pushed to a queue together with the inputs to drive and the outputs
// expected in that cycle. On every falling edge, one entry is popped, the outputs are checked,
// and the entry's inputs are applied for the next rising edge.
//
// Expected-output vector layout:
//   {input_en, load_in, sel_old_or_new, mul_en, sum_en, busy, done, timeout, iter_cnt[3:0]}
module tb_maxnet_controller;

  localparam int unsigned TbMaxIter = 4;
`ifdef MAXNET_TIMEOUT_EN
  localparam int Limit = TbMaxIter;
`else
  localparam int Limit = 0;
`endif

  logic       clk;
  logic       rst;
  logic       start;
  logic       S;
  logic       input_en;
  logic       load_in;
  logic       sel_old_or_new;
  logic       mul_en;
  logic       sum_en;
  logic       busy;
  logic       done;
  logic       timeout;
  logic [3:0] iter_cnt;

  maxnet_controller #(
    .MAX_ITER(TbMaxIter)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .S             (S),
    .input_en      (input_en),
    .load_in       (load_in),
    .sel_old_or_new(sel_old_or_new),
    .mul_en        (mul_en),
    .sum_en        (sum_en),
    .busy          (busy),
    .done          (done),
    .timeout       (timeout),
    .iter_cnt      (iter_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        st;
    logic        s;
    logic [11:0] exp;
    int          tag;
  } ent_t;

  ent_t q[$];
  int   n_cmp;
  int   n_fail;
  int   tag_n;
  int   prev_cnt;
  bit   prev_to;

  function automatic logic [11:0] mk(bit ie, bit li, bit sel, bit mu, bit su, bit bz, bit dn,
                                     bit to, int cnt);
    logic [3:0] c;
    c = 4'(cnt);
    return {ie, li, sel, mu, su, bz, dn, to, c};
  endfunction

  function automatic logic [11:0] obs();
    return {input_en, load_in, sel_old_or_new, mul_en, sum_en, busy, done, timeout, iter_cnt};
  endfunction

  task automatic check(int tag, logic [11:0] o, logic [11:0] e);
    n_cmp++;
    assert (o === e)
    else begin
      n_fail++;
      $error("FAIL step%0d: got %h, want %h", tag, o, e);
    end
  endtask

  task automatic push(bit st, bit s, logic [11:0] e);
    ent_t x;
    x.st  = st;
    x.s   = s;
    x.exp = e;
    x.tag = tag_n;
    tag_n++;
    q.push_back(x);
  endtask

  // Plans one run.
  //   n_conv    - iteration at which S=1 (0 means never).
  //   stop_iter - stop planning after the MUL cycle of that iteration (0 means run to completion).
  //   spur      - drive S high during LOAD_PU..SUM.
  //   busy_st   - toggle start while the controller is busy, and hold it through DONE.
  task automatic plan_run(int n_conv, int stop_iter, bit spur, bit busy_st);
    int cnt;
    int cnt_next;
    bit conv;
    bit tmo;
    bit fin;
    push(1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, prev_to, prev_cnt));
    push(1'b0, 1'b0, mk(1, 0, 0, 0, 0, 1, 0, 0, 0));
    fin = 1'b0;
    for (int it = 1; it <= 40 && !fin; it++) begin
      cnt = (it - 1 > 15) ? 15 : it - 1;
      push(1'b0, spur, mk(0, 1, it > 1, 0, 0, 1, 0, 0, cnt));
      push(busy_st, spur, mk(0, 0, 0, 1, 0, 1, 0, 0, cnt));
      if (it == stop_iter) return;
      push(1'b0, spur, mk(0, 0, 0, 0, 1, 1, 0, 0, cnt));
      cnt_next = (it > 15) ? 15 : it;
      conv = (it == n_conv);
      tmo  = (Limit != 0) && (it == Limit) && !conv;
      push(busy_st, conv, mk(0, 0, 0, 0, 0, 1, 0, 0, cnt));
      if (conv || tmo) begin
        push(busy_st, 1'b0, mk(0, 0, 0, 0, 0, 1, 1, tmo, cnt_next));
        prev_cnt = cnt_next;
        prev_to  = tmo;
        fin      = 1'b1;
      end
    end
  endtask

  task automatic drain();
    ent_t e;
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      check(e.tag, obs(), e.exp);
      start = e.st;
      S     = e.s;
    end
  endtask

  // Called on a falling edge mid-run. Pulses rst asynchronously and checks that the outputs
  // clear at once.
  task automatic async_reset(int tag);
    #2 rst = 1'b1;
    #1 check(tag, obs(), 12'h000);
    @(negedge clk);
    check(tag + 1, obs(), 12'h000);
    rst      = 1'b0;
    start    = 1'b0;
    S        = 1'b0;
    prev_cnt = 0;
    prev_to  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    tag_n    = 0;
    prev_cnt = 0;
    prev_to  = 1'b0;
    rst      = 1'b1;
    start    = 1'b0;
    S        = 1'b0;
    #3 check(9000, obs(), 12'h000);
    @(negedge clk);
    check(9001, obs(), 12'h000);
    rst = 1'b0;

    // With start low, the controller stays idle.
    push(1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    push(1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    drain();

    // Convergence at the first CHECK.
    plan_run(1, 0, 1'b0, 1'b0);
    drain();

    // Convergence at the third CHECK.
    plan_run(3, 0, 1'b0, 1'b0);
    drain();

    // Spurious S outside CHECK.
    plan_run(2, 0, 1'b1, 1'b0);
    drain();

    // Start while busy. The next run chains directly after the done pulse.
    plan_run(2, 0, 1'b0, 1'b1);
    plan_run(1, 0, 1'b0, 1'b0);
    drain();

    // Reset during MUL of iteration 2, then a clean run.
    plan_run(0, 2, 1'b0, 1'b0);
    drain();
    async_reset(9100);
    plan_run(1, 0, 1'b0, 1'b0);
    drain();

`ifdef MAXNET_TIMEOUT_EN
    // S held low: the run times out after TbMaxIter iterations.
    // The next start clears timeout.
    plan_run(0, 0, 1'b0, 1'b0);
    plan_run(1, 0, 1'b0, 1'b0);
    drain();
`else
    // S held low: no done, and iter_cnt saturates at 15.
    plan_run(0, 18, 1'b0, 1'b0);
    drain();
    async_reset(9200);
    plan_run(1, 0, 1'b0, 1'b0);
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/maxnet_controller.md
MAXNET_CONTROLLER -- requirements
Module: maxnet_controller

Interface
REQ-001 SHALL have parameter MAX_ITER, default 15: iteration limit used when MAXNET_TIMEOUT_EN is defined; legal range 1..15.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: request to process a new x1..x4 set; sampled in IDLE only.
REQ-005 SHALL have port S, input, 1: datapath convergence flag; 1 = at most one PU output nonzero.
REQ-006 SHALL have port input_en, output, 1: loads the input X registers.
REQ-007 SHALL have port load_in, output, 1: loads the PU input registers.
REQ-008 SHALL have port sel_old_or_new, output, 1: 0 selects X registers, 1 selects fed-back PU outputs.
REQ-009 SHALL have port mul_en, output, 1: PU multiply-stage enable.
REQ-010 SHALL have port sum_en, output, 1: PU sum-stage enable.
REQ-011 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-012 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-013 SHALL have port timeout, output, 1: completion caused by the iteration limit; valid while done=1.
REQ-014 SHALL have port iter_cnt, output, 4: number of completed iterations.

Function
REQ-015 SHALL implement the states IDLE, LOAD_X, LOAD_PU, MUL, SUM, CHECK and DONE, all registered.
REQ-016 SHALL, in IDLE with start=1 at an edge, go to LOAD_X and clear iter_cnt; with start=0, SHALL stay in IDLE.
REQ-017 SHALL, in LOAD_X, assert input_en=1 for exactly one cycle and then go to LOAD_PU.
REQ-018 SHALL, in LOAD_PU, assert load_in=1 and then go to MUL.
REQ-019 SHALL drive sel_old_or_new=0 in the first LOAD_PU of a run and 1 in every later LOAD_PU.
REQ-020 SHALL, in MUL, assert mul_en=1 and then go to SUM.
REQ-021 SHALL, in SUM, assert sum_en=1 and then go to CHECK.
REQ-022 SHALL, in CHECK, sample S and increment iter_cnt by 1.
REQ-023 SHALL, when S=1 in CHECK, go to DONE.
REQ-024 SHALL, when S=0 in CHECK, go to LOAD_PU, subject to REQ-031.
REQ-025 SHALL, in DONE, assert done=1 for exactly one cycle and then return to IDLE.
REQ-026 SHALL hold iter_cnt and timeout at their final values until the next accepted start.
REQ-027 SHALL assert at most one of input_en, load_in, mul_en or sum_en in any cycle; sel_old_or_new SHALL be 0 outside LOAD_PU.
REQ-028 SHALL ignore start while busy=1; a start that is held high is accepted again only after returning to IDLE.
REQ-029 SHALL fix latency at: start edge -> input_en asserted 1 cycle later; first done pulse asserted 5 + 4*(N-1) cycles after LOAD_X, where N is the iteration at which S=1.
REQ-030 SHALL ignore S outside CHECK.

Reset
REQ-031 SHALL, on rst=1 at any time (including mid-run), immediately force state=IDLE and drive all outputs to 0, including iter_cnt=0 and timeout=0.
REQ-032 SHALL, after rst deasserts, resume normal operation from IDLE on the first rising edge.

Configuration
REQ-033 SHALL provide the macro MAXNET_TIMEOUT_EN.
REQ-034 SHALL, with MAXNET_TIMEOUT_EN defined, go from CHECK to DONE with timeout=1 when S=0 and the incremented iter_cnt equals MAX_ITER.
REQ-035 SHALL, with MAXNET_TIMEOUT_EN defined and S=1 in CHECK, take priority over the limit and finish with timeout=0.
REQ-036 SHALL, without MAXNET_TIMEOUT_EN, iterate until S=1, tie timeout to 0, and saturate iter_cnt at 15.

Verification
REQ-037 Bench SHALL cover convergence: start pulse, S=1 at the first CHECK -> sequence input_en, load_in(sel=0), mul_en, sum_en, then done=1 five cycles after LOAD_X, iter_cnt=1, timeout=0.
REQ-038 Bench SHALL cover multiple iterations: S=1 at the third CHECK -> second and third load_in have sel_old_or_new=1, done 13 cycles after LOAD_X, iter_cnt=3.
REQ-039 Bench SHALL cover timeout: MAXNET_TIMEOUT_EN defined, MAX_ITER=4, S held 0 -> done=1, timeout=1, iter_cnt=4 after 4 iterations; without the macro, no done and iter_cnt saturates at 15.
REQ-040 Bench SHALL cover reset mid-run: rst pulsed asynchronously during MUL of iteration 2 -> all outputs 0 immediately, busy=0, and a new start runs normally with sel_old_or_new=0 in the first LOAD_PU.
REQ-041 Bench SHALL cover start while busy: start toggled during SUM and held high through DONE -> no restart mid-run; a new run begins with input_en 2 cycles after the done pulse.
REQ-042 Bench SHALL cover spurious S: S=1 during MUL and SUM and 0 at CHECK -> the run continues to the next LOAD_PU.
